// File: rtl/rf_arb_pkg.sv
// Shared types and width defaults for the register-file writeback arbiter.
package rf_arb_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 64;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] rd;
        logic [RF_DATA_W-1:0] wdata;
    } wb_entry_t;

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// DEPTH-entry synchronous FIFO of writeback entries; head is the oldest entry,
// valid whenever empty is low.
module rf_wb_fifo
    import rf_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             push,
    input  logic             pop,
    input  wb_entry_t        din,
    output wb_entry_t        head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset && do_push) mem_q[wptr_q] <= din;
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-port arbiter: pipeline writeback (A) always wins, long-latency results (B)
// drain from a FIFO into idle slots. Starvation guard under RF_ARB_STARVE_GUARD_EN.
module rf_wb_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     a_we,
    input  logic [ADDR_W-1:0]        a_rd,
    input  logic [DATA_W-1:0]        a_wdata,
    input  logic                     b_valid,
    output logic                     b_ready,
    input  logic [ADDR_W-1:0]        b_rd,
    input  logic [DATA_W-1:0]        b_wdata,
    output logic                     stall_req,
    output logic [$clog2(DEPTH):0]   b_pending,
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_rd,
    output logic [DATA_W-1:0]        rf_wdata
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAX_WAIT < 1) begin : g_bad_params
        $error("rf_wb_arbiter: DEPTH must be a power of two >= 2 and MAX_WAIT >= 1");
    end

    logic      a_eff, fifo_push, fifo_pop, fifo_full, fifo_empty;
    wb_entry_t fifo_din, fifo_head;

    assign a_eff     = a_we && (a_rd != '0);
    assign b_ready   = !fifo_full;
    // x0 results are handshaken but never stored.
    assign fifo_push = b_valid && !fifo_full && (b_rd != '0);
    // The flush cycle must not leak a buffered result into the file.
    assign fifo_pop  = !a_eff && !fifo_empty && !Reset;
    assign fifo_din  = '{rd: b_rd, wdata: b_wdata};

    rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .Clk   (Clk),
        .Reset (Reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .head  (fifo_head),
        .count (b_pending),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        rf_we    = 1'b0;
        rf_rd    = '0;
        rf_wdata = '0;
        if (a_eff) begin
            rf_we    = 1'b1;
            rf_rd    = a_rd;
            rf_wdata = a_wdata;
        end else if (fifo_pop) begin
            rf_we    = 1'b1;
            rf_rd    = fifo_head.rd;
            rf_wdata = fifo_head.wdata;
        end
    end

`ifdef RF_ARB_STARVE_GUARD_EN
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    arb_state_t        state_q, state_d;
    logic              head_denied;

    assign head_denied = !fifo_empty && !fifo_pop;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wait_q  <= '0;
            state_q <= NORMAL;
        end else begin
            wait_q  <= wait_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        wait_d    = wait_q;
        state_d   = state_q;
        if (fifo_pop || fifo_empty)               wait_d = '0;
        else if (wait_q != WAIT_W'(MAX_WAIT))     wait_d = wait_q + 1'b1;
        case (state_q)
            NORMAL: if (head_denied && wait_q == WAIT_W'(MAX_WAIT - 1)) state_d = FORCE;
            FORCE:  if (fifo_pop) state_d = NORMAL;
            default: state_d = NORMAL;
        endcase
        stall_req = (state_q == FORCE);
    end
`else
    assign stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: B entries are queued when driven and
// popped when the arbiter is expected to grant them.
module tb_rf_wb_arbiter;
    import rf_arb_pkg::*;

    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;
`ifdef RF_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic        a_we, b_valid;
    logic [4:0]  a_rd, b_rd;
    logic [63:0] a_wdata, b_wdata;
    logic        b_ready, stall_req, rf_we;
    logic [1:0]  b_pending;
    logic [4:0]  rf_rd;
    logic [63:0] rf_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    wb_entry_t sb[$];
    int        m_wait  = 0;
    bit        m_force = 1'b0;

    always #5 Clk = ~Clk;

    rf_wb_arbiter #(.DATA_W(64), .ADDR_W(5), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .Clk(Clk), .Reset(Reset),
        .a_we(a_we), .a_rd(a_rd), .a_wdata(a_wdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_wdata(b_wdata),
        .stall_req(stall_req), .b_pending(b_pending),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: compare outputs against the model, then advance the model at posedge.
    task automatic tick();
        logic        ewe;
        logic [4:0]  erd;
        logic [63:0] ed;
        bit          do_pop, do_push, was_empty;
        #3;
        ewe = 1'b0; erd = '0; ed = '0; do_pop = 1'b0;
        if (a_we && a_rd != 0) begin
            ewe = 1'b1; erd = a_rd; ed = a_wdata;
        end else if (!Reset && sb.size() > 0) begin
            ewe = 1'b1; erd = sb[0].rd; ed = sb[0].wdata; do_pop = 1'b1;
        end
        chk("rf_we", rf_we, ewe);
        chk("rf_rd", rf_rd, erd);
        chk("rf_wdata", rf_wdata, ed);
        chk("b_ready", b_ready, sb.size() < DEPTH);
        chk("b_pending", b_pending, sb.size());
        chk("stall_req", stall_req, m_force);
        do_push   = b_valid && sb.size() < DEPTH && b_rd != 0;
        was_empty = (sb.size() == 0);
        @(posedge Clk);
        if (Reset) begin
            sb.delete();
            m_wait  = 0;
            m_force = 1'b0;
        end else begin
            if (GUARD) begin
                if (!m_force && !was_empty && !do_pop && m_wait == MAX_WAIT - 1) m_force = 1'b1;
                else if (m_force && do_pop) m_force = 1'b0;
                if (do_pop || was_empty) m_wait = 0;
                else if (m_wait < MAX_WAIT) m_wait++;
            end
            if (do_pop)  void'(sb.pop_front());
            if (do_push) sb.push_back('{rd: b_rd, wdata: b_wdata});
        end
        #1;
    endtask

    task automatic idle();
        a_we = 0; a_rd = 0; a_wdata = 0; b_valid = 0; b_rd = 0; b_wdata = 0;
    endtask

    initial begin
        idle();
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        chk("rst_b_ready", b_ready, 1);
        chk("rst_stall", stall_req, 0);
        chk("rst_pending", b_pending, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_rd", rf_rd, 0);
        chk("rst_rf_wdata", rf_wdata, 0);

        // A path is combinational
        a_we = 1; a_rd = 5; a_wdata = 64'hAA;
        #1;
        chk("a_we", rf_we, 1);
        chk("a_rd", rf_rd, 5);
        chk("a_wdata", rf_wdata, 64'hAA);
        tick();

        // B single entry drains next cycle
        idle(); b_valid = 1; b_rd = 7; b_wdata = 64'h1234;
        tick();
        idle();
        #1;
        chk("b1_we", rf_we, 1);
        chk("b1_rd", rf_rd, 7);
        chk("b1_data", rf_wdata, 64'h1234);
        chk("b1_pend", b_pending, 1);
        tick();
        chk("b1_pend0", b_pending, 0);

        // Starvation: A busy, two B entries fill the FIFO
        a_we = 1; a_rd = 9; a_wdata = 64'h99;
        b_valid = 1; b_rd = 11; b_wdata = 64'hB11;
        tick();
        b_rd = 12; b_wdata = 64'hB12;
        tick();
        b_valid = 0;
        chk("full_ready", b_ready, 0);
        chk("full_pend", b_pending, 2);
        repeat (2) tick();
        chk("stall_early", stall_req, 0);
        tick();
        chk("stall_rise", stall_req, GUARD);
        tick();
        chk("stall_hold", stall_req, GUARD);
        a_we = 0;
        #1;
        chk("force_rd", rf_rd, 11);
        chk("force_data", rf_wdata, 64'hB11);
        tick();
        chk("stall_fall", stall_req, 0);
        tick();
        chk("drain_pend", b_pending, 0);

        // x0 A write frees the slot
        a_we = 1; a_rd = 4; a_wdata = 64'h44;
        b_valid = 1; b_rd = 3; b_wdata = 64'h33;
        tick();
        b_valid = 0; a_rd = 0; a_wdata = 64'hDEAD;
        #1;
        chk("x0_slot_rd", rf_rd, 3);
        chk("x0_slot_data", rf_wdata, 64'h33);
        tick();
        #1;
        chk("x0_no_we", rf_we, 0);
        tick();

        // B to x0 is discarded
        idle(); b_valid = 1; b_rd = 0; b_wdata = 64'h77;
        tick();
        idle();
        chk("bx0_pend", b_pending, 0);
        #1;
        chk("bx0_we", rf_we, 0);
        tick();

        // Reset while full (and forced when guarded)
        a_we = 1; a_rd = 2; a_wdata = 64'h22;
        b_valid = 1; b_rd = 20; b_wdata = 64'h2020;
        tick();
        b_rd = 21; b_wdata = 64'h2121;
        tick();
        b_valid = 0;
        repeat (4) tick();
        chk("pre_rst_stall", stall_req, GUARD);
        a_we = 0; Reset = 1;
        tick();
        Reset = 0;
        chk("mid_rst_pend", b_pending, 0);
        chk("mid_rst_stall", stall_req, 0);
        chk("mid_rst_ready", b_ready, 1);
        repeat (3) begin
            tick();
            chk("mid_rst_no_b", rf_we, 0);
        end

        // Random traffic against the scoreboard
        for (int i = 0; i < 400; i++) begin
            a_we    = ($urandom_range(0, 99) < 60);
            a_rd    = 5'($urandom_range(0, 31));
            a_wdata = {$urandom, $urandom};
            b_valid = ($urandom_range(0, 99) < 40);
            b_rd    = 5'($urandom_range(0, 31));
            b_wdata = {$urandom, $urandom};
            Reset   = ($urandom_range(0, 99) < 2);
            tick();
        end
        Reset = 0;
        idle();
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port arbiter for the 32x64 register file. Two writeback sources share the file's single write port: the in-order pipeline writeback (source A, no backpressure) and a long-latency unit such as a divider (source B, valid/ready). A always has priority. B results are buffered in a small FIFO and drained into idle write slots, with an optional starvation guard that stalls the pipeline to force a slot.

## Interface
- DATA_W, 64, write data width
- ADDR_W, 5, register index width
- DEPTH, 2, B-side FIFO entries (power of 2, ≥2)
- MAX_WAIT, 4, cycles a non-empty FIFO head may wait before forcing a slot (≥1)

Ports:
- Clk  in  1  clock; all state updates on posedge
- Reset  in  1  reset; synchronous, active-high
- a_we  in  1  pipeline writeback enable
- a_rd  in  ADDR_W  pipeline destination register
- a_wdata  in  DATA_W  pipeline writeback data
- b_valid  in  1  long-latency result valid
- b_ready  out  1  FIFO can accept a result
- b_rd  in  ADDR_W  long-latency destination register
- b_wdata  in  DATA_W  long-latency result data
- stall_req  out  1  request to the pipeline to hold a_we low
- b_pending  out  $clog2(DEPTH)+1  FIFO occupancy
- rf_we  out  1  register-file RegWrite
- rf_rd  out  ADDR_W  register-file RD
- rf_wdata  out  DATA_W  register-file WriteData

## Operation
- Effective A write: a_eff = a_we && a_rd != 0. Writes to x0 free the slot.
- Grant, combinational: if a_eff, drive rf_* from A. Else if the FIFO is non-empty, drive rf_* from the FIFO head and pop it. Else rf_we=0, and rf_rd/rf_wdata are 0.
- Enqueue: on b_valid && b_ready. b_ready = (count < DEPTH), with no same-cycle pass-through when full. A B entry with b_rd=0 is accepted and discarded (not enqueued).
- Push and pop in the same cycle: count is unchanged. Pointers wrap modulo DEPTH.
- Wait counter: cleared on pop or when the FIFO is empty. Otherwise it increments while the head is not granted, saturating at MAX_WAIT.
- FSM (Moore), states NORMAL and FORCE:
  - NORMAL→FORCE when the head is not granted and wait == MAX_WAIT-1.
  - FORCE→NORMAL on the cycle the head is popped.
  - stall_req = (state == FORCE).
- In FORCE, A still wins if the pipeline ignores stall_req. The arbiter never drops an A write.
- No reordering within B. Ordering of A vs B writes to the same register is the issuing scoreboard's responsibility and is not checked here.

## Timing
- A path: zero latency, combinational from a_* to rf_*. The register file commits on the following negedge.
- B path: minimum 1 cycle, from enqueue at posedge to rf_* valid in the next cycle if the slot is free.
- stall_req rises one cycle after the MAX_WAIT-th consecutive denied cycle. It falls in the cycle after the forced pop.
- Reset values:
  - FIFO empty, count=0, wait=0, state NORMAL.
  - b_ready=1, stall_req=0, b_pending=0.
  - rf_we=0, rf_rd=0, rf_wdata=0 when a_we=0.
- Reset mid-operation flushes the FIFO and returns to NORMAL. Buffered results are lost.

## Configuration
- RF_ARB_STARVE_GUARD_EN defined: the wait counter and FSM are present, and stall_req behaves as above.
- RF_ARB_STARVE_GUARD_EN undefined: no counter or FSM, stall_req tied 0, and B drains only in A-idle cycles.

## Structure
- Package rf_arb_pkg holds:
  - ADDR_W/DATA_W defaults
  - typedef wb_entry_t {rd, wdata}
  - typedef enum arb_state_t {NORMAL, FORCE}
- Sub-module rf_wb_fifo: a DEPTH-entry synchronous FIFO of wb_entry_t, exposing push, pop, head, count, full and empty.

## Test plan
- Reset, then a_we=1, a_rd=5, a_wdata=0xAA → same cycle rf_we=1, rf_rd=5, rf_wdata=0xAA, b_ready=1, stall_req=0.
- a_we=0, push B (rd=7, data=0x1234) → next cycle rf_we=1, rf_rd=7, rf_wdata=0x1234; b_pending goes 1→0.
- a_we=1 every cycle, push 2 B entries → b_ready=0 after the second push. stall_req=1 on the cycle after 4 denied cycles. Drop a_we → head (first entry) is written, and stall_req=0 the cycle after.
- a_we=1 with a_rd=0 while the FIFO holds rd=3 → rf_rd=3 written. A write to x0 never reaches rf_we.
- Push B with b_rd=0 → b_pending stays 0 and rf_we never rises.
- FIFO full and in FORCE, assert Reset for one cycle → b_pending=0, stall_req=0, b_ready=1, and no B write ever appears.
